// File: rtl/mem_access_ctrl.sv
// MAR/MDR/SRAM access sequencer: one load or store at a time, programmable wait states.
// Outputs are a decode of the state, flopped alongside it so they change only on Clk.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Req,
  input  logic Write,
  output logic Busy,
  output logic Done,
  output logic LD_MAR,
  output logic LD_MDR,
  output logic MIO_EN,
  output logic CE_N,
  output logic OE_N,
  output logic WE_N
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    RD_WAIT  = 3'd2,
    RD_LATCH = 3'd3,
    WR_LOAD  = 3'd4,
    WR_PULSE = 3'd5,
    WR_HOLD  = 3'd6,
    DONE     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic busy_d, done_d, ld_mar_d, ld_mdr_d, mio_en_d, ce_n_d, oe_n_d, we_n_d;
  logic busy_q, done_q, ld_mar_q, ld_mdr_q, mio_en_q, ce_n_q, oe_n_q, we_n_q;

  // State, captured direction, wait counter and output flops
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ld_mar_q <= 1'b0;
      ld_mdr_q <= 1'b0;
      mio_en_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ld_mar_q <= ld_mar_d;
      ld_mdr_q <= ld_mdr_d;
      mio_en_q <= mio_en_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
    end
  end

  // Next-state logic; Req/Write only matter in IDLE
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Req) begin
          wr_d    = Write;
          state_d = ADDR;
        end
      end
      ADDR: begin
        cnt_d   = '0;
        state_d = wr_q ? WR_LOAD : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = RD_LATCH;
      end
      RD_LATCH: state_d = DONE;
      WR_LOAD: begin
        cnt_d   = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = WR_HOLD;
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the state being entered, so the flops track state_q exactly
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = 1'b0;
    ld_mar_d = 1'b0;
    ld_mdr_d = 1'b0;
    mio_en_d = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    case (state_d)
      ADDR: ld_mar_d = 1'b1;
      RD_WAIT: begin
        ce_n_d   = 1'b0;
        oe_n_d   = 1'b0;
        mio_en_d = 1'b1;
      end
      RD_LATCH: begin
        ce_n_d   = 1'b0;
        oe_n_d   = 1'b0;
        mio_en_d = 1'b1;
        ld_mdr_d = 1'b1;
      end
      WR_LOAD: ld_mdr_d = 1'b1;
      WR_PULSE: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
      end
      WR_HOLD: ce_n_d = 1'b0;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign LD_MAR = ld_mar_q;
  assign LD_MDR = ld_mdr_q;
  assign MIO_EN = mio_en_q;
  assign CE_N   = ce_n_q;
  assign OE_N   = oe_n_q;
  assign WE_N   = we_n_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (WAIT_CYCLES 1, 2, 5) with a Done-cycle scoreboard.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] wr  = '0;
  logic [2:0] busy, done, ld_mar, ld_mdr, mio_en, ce_n, oe_n, we_n;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(.WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 2 : 5)) u_dut (
      .Clk(clk), .Reset(rst), .Req(req[g]), .Write(wr[g]),
      .Busy(busy[g]), .Done(done[g]), .LD_MAR(ld_mar[g]), .LD_MDR(ld_mdr[g]),
      .MIO_EN(mio_en[g]), .CE_N(ce_n[g]), .OE_N(oe_n[g]), .WE_N(we_n[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drive a one-cycle request on the masked instances, optionally scoreboarding Done
  task automatic start(input logic [2:0] m, input logic w, input bit push);
    req = m;
    wr  = {3{w}};
    if (push)
      for (int k = 0; k < 3; k++)
        if (m[k]) exp_q[k].push_back(cyc + (w ? 4 : 3) + wc(k));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; i++)
      tick();
    chk("drain_timeout", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    sample();
    chk("idle_after_txn", 32'(busy), 32'd0);
    tick();
  endtask

  // Done timing against the scoreboard plus strobe invariants, every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        int e;
        chk("inv_oe_we", 32'(oe_n[k] | we_n[k]), 32'd1);
        chk("inv_ldmar_ldmdr", 32'(ld_mar[k] & ld_mdr[k]), 32'd0);
        chk("inv_mio_oe", 32'(mio_en[k] & oe_n[k]), 32'd0);
        if (done[k] === 1'b1) begin
          e = (exp_q[k].size() == 0) ? -1 : exp_q[k].pop_front();
          chk($sformatf("done_cycle_%0d", k), 32'(cyc), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles with Req high
    rst = 1'b1; req = 3'b111; wr = 3'b000;
    tick(); mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ce_oe_we", 32'({ce_n, oe_n, we_n}), 32'h1FF);
      chk("rst_ld_mio", 32'({ld_mar, ld_mdr, mio_en}), 32'd0);
      tick();
    end
    rst = 1'b0; req = '0;
    sample();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Read on all instances; detailed waveform on WAIT_CYCLES=2
    tick(); start(3'b111, 1'b0, 1'b1);
    sample(); chk("rd_c0_busy", 32'(busy[1]), 32'd0);
    tick(); req = '0;
    sample(); chk("rd_c1_ldmar", 32'(ld_mar[1]), 32'd1); chk("rd_c1_busy", 32'(busy[1]), 32'd1);
    tick();
    sample(); chk("rd_c2_ce_oe", 32'({ce_n[1], oe_n[1]}), 32'd0); chk("rd_c2_mio", 32'(mio_en[1]), 32'd1);
    tick();
    sample(); chk("rd_c3_oe", 32'(oe_n[1]), 32'd0); chk("rd_c3_ldmdr", 32'(ld_mdr[1]), 32'd0);
    tick();
    sample(); chk("rd_c4_oe", 32'(oe_n[1]), 32'd0); chk("rd_c4_ldmdr_mio", 32'({ld_mdr[1], mio_en[1]}), 32'd3);
    tick();
    sample(); chk("rd_c5_done", 32'(done[1]), 32'd1); chk("rd_c5_oe", 32'(oe_n[1]), 32'd1);
    drain();

    // Write on all instances; detailed waveform on WAIT_CYCLES=2
    start(3'b111, 1'b1, 1'b1);
    sample(); chk("wr_c0_busy", 32'(busy[1]), 32'd0);
    tick(); req = '0;
    sample(); chk("wr_c1_ldmar", 32'(ld_mar[1]), 32'd1);
    tick();
    sample(); chk("wr_c2_ldmdr_mio", 32'({ld_mdr[1], mio_en[1]}), 32'd2); chk("wr_c2_ce", 32'(ce_n[1]), 32'd1);
    tick();
    sample(); chk("wr_c3_we_ce", 32'({we_n[1], ce_n[1]}), 32'd0); chk("wr_c3_oe", 32'(oe_n[1]), 32'd1);
    tick();
    sample(); chk("wr_c4_we", 32'(we_n[1]), 32'd0);
    tick();
    sample(); chk("wr_c5_hold", 32'({we_n[1], ce_n[1]}), 32'd2); chk("wr_c5_done", 32'(done[1]), 32'd0);
    tick();
    sample(); chk("wr_c6_done", 32'(done[1]), 32'd1);
    drain();

    // Req held high on WAIT_CYCLES=2: read then write, Write flipped mid-read
    for (int t = 0; t < 14; t++) begin
      if (t == 0) begin
        req[1] = 1'b1; wr[1] = 1'b0;
        exp_q[1].push_back(cyc + 5);
        exp_q[1].push_back(cyc + 12);
      end
      if (t == 2) wr[1] = 1'b1;
      if (t == 7) req[1] = 1'b0;
      sample();
      case (t)
        2:  chk("b2b_rd_oe", 32'(oe_n[1]), 32'd0);
        3:  chk("b2b_rd_we", 32'({we_n[1], oe_n[1]}), 32'd2);
        5:  chk("b2b_rd_done", 32'(done[1]), 32'd1);
        6:  chk("b2b_idle_gap", 32'({busy[1], ld_mar[1]}), 32'd0);
        7:  chk("b2b_wr_ldmar", 32'(ld_mar[1]), 32'd1);
        8:  chk("b2b_wr_ldmdr", 32'({ld_mdr[1], mio_en[1]}), 32'd2);
        12: chk("b2b_wr_done", 32'(done[1]), 32'd1);
        default: ;
      endcase
      tick();
    end
    chk("b2b_others_idle", 32'({busy[2], busy[0]}), 32'd0);
    drain();

    // Reset during WR_PULSE: transaction dropped, no Done
    start(3'b111, 1'b1, 1'b0);
    tick(); req = '0;
    tick();
    tick();
    sample(); chk("rstwr_pulse_we", 32'(we_n), 32'd0); chk("rstwr_pulse_ce", 32'(ce_n), 32'd0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    sample();
    chk("rstwr_we", 32'(we_n), 32'h7);
    chk("rstwr_ce", 32'(ce_n), 32'h7);
    chk("rstwr_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick(); sample();
      chk("rstwr_no_done", 32'(done), 32'd0);
    end

    // One more read/write per instance to confirm recovery after the dropped transaction
    tick(); start(3'b111, 1'b0, 1'b1);
    tick(); req = '0;
    drain();
    start(3'b111, 1'b1, 1'b1);
    tick(); req = '0;
    drain();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
